// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : packs a byte stream into words and writes them to instruction memory
// Revision : 1.0
// ============================================================================
module prog_loader #(
   parameter int BYTE_W     = 8,
   parameter int WORD_BYTES = 2,
   parameter int ADDR_WIDTH = 7,
   parameter int DEPTH      = 128
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_mode,
   input  logic                         in_valid,
   input  logic [BYTE_W-1:0]            in_data,
   output logic                         in_ready,
   output logic                         mem_we,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [BYTE_W*WORD_BYTES-1:0] mem_wdata,
   output logic [ADDR_WIDTH:0]          word_count,
   output logic [BYTE_W-1:0]            checksum,
   output logic                         err,
   output logic                         cpu_run
);

   localparam int                    c_WORD_W   = BYTE_W * WORD_BYTES;
   localparam int                    c_IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(WORD_BYTES - 1);
   localparam logic [ADDR_WIDTH:0]   c_FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_ASSEMBLE = 3'd1;
   localparam logic [2:0] c_WRITE    = 3'd2;
   localparam logic [2:0] c_FLUSH    = 3'd3;
   localparam logic [2:0] c_DONE     = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic [c_IDX_W-1:0]  r_byte_idx;
   logic [c_WORD_W-1:0] r_buf;
   logic [c_WORD_W-1:0] w_merged;
   logic                w_full;
   logic                w_accept;
   logic                w_last;
   logic                w_overflow;
   logic                w_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:     if (load_mode) w_state_nxt = c_ASSEMBLE;
         c_ASSEMBLE: begin
            if (!load_mode)
               w_state_nxt = (r_byte_idx == '0) ? c_DONE : c_FLUSH;
            else if (w_accept && w_last)
               w_state_nxt = c_WRITE;
         end
         c_WRITE:    w_state_nxt = c_ASSEMBLE;
         c_FLUSH:    w_state_nxt = c_DONE;
         c_DONE:     if (load_mode) w_state_nxt = c_ASSEMBLE;
         default:    w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_full     = (word_count == c_FULL_CNT);
      in_ready   = (r_state == c_ASSEMBLE) && load_mode && !w_full;
      w_accept   = in_ready && in_valid;
      w_last     = (r_byte_idx == c_LAST_IDX);
      w_overflow = (r_state == c_ASSEMBLE) && load_mode && in_valid && w_full;
      w_start    = ((r_state == c_IDLE) || (r_state == c_DONE)) && load_mode;
      w_merged   = r_buf;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (r_byte_idx == c_IDX_W'(i)) w_merged[i*BYTE_W +: BYTE_W] = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         checksum   <= '0;
         err        <= 1'b0;
         cpu_run    <= 1'b0;
         r_byte_idx <= '0;
         r_buf      <= '0;
      end else begin
         mem_we <= 1'b0;
         if (w_start) begin
            mem_addr   <= '0;
            word_count <= '0;
            checksum   <= '0;
            err        <= 1'b0;
            cpu_run    <= 1'b0;
            r_byte_idx <= '0;
            r_buf      <= '0;
         end
         if (r_state == c_ASSEMBLE) begin
            if (w_overflow) err <= 1'b1;
            if (w_accept) begin
               checksum <= checksum + in_data;
               if (w_last) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= w_merged;
               end else begin
                  r_buf      <= w_merged;
                  r_byte_idx <= r_byte_idx + 1'b1;
               end
            end else if (!load_mode && (r_byte_idx != '0)) begin
               // Partial word: unfilled lanes are still zero from the last clear
               mem_we    <= 1'b1;
               mem_wdata <= r_buf;
            end
         end
         if ((r_state == c_WRITE) || (r_state == c_FLUSH)) begin
            word_count <= word_count + 1'b1;
            if (mem_addr != '1) mem_addr <= mem_addr + 1'b1;
            r_byte_idx <= '0;
            r_buf      <= '0;
         end
         if ((w_state_nxt == c_DONE) && (r_state != c_DONE)) cpu_run <= !err;
      end
   end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Parametrised program-load engine between the chip pin interface and the RISC core's instruction memory. It accepts a byte stream with a valid/ready handshake and assembles bytes into instruction words of configurable width. It writes each word to sequential memory addresses and tracks word count, a byte checksum and overflow. When loading ends it flushes any partial word and releases the core to run.

## Interface
- BYTE_W, 8: width of one input byte.
- WORD_BYTES, 2: bytes per instruction word (≥1); word width = BYTE_W*WORD_BYTES.
- ADDR_WIDTH, 7: instruction memory address width.
- DEPTH, 128: words the memory holds (1 ≤ DEPTH ≤ 2**ADDR_WIDTH).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_mode  in  1  level; 1 = host is loading, 0 = end of load.
- in_valid  in  1  input byte present.
- in_data  in  BYTE_W  input byte.
- in_ready  out  1  byte accepted this cycle when in_valid & in_ready.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  BYTE_W*WORD_BYTES  write data.
- word_count  out  ADDR_WIDTH+1  words written in current load.
- checksum  out  BYTE_W  modulo-2**BYTE_W sum of accepted bytes.
- err  out  1  sticky overflow flag.
- cpu_run  out  1  core may execute.

## Operation
- States: IDLE, ASSEMBLE, WRITE, FLUSH, DONE.
- IDLE: waits for load_mode=1. On entry to ASSEMBLE from IDLE or DONE, clear mem_addr, word_count, checksum, byte index, word buffer and err.
- ASSEMBLE, load_mode=1:
  - in_ready = !full, where full = (word_count == DEPTH).
  - On an accepted byte: place it at byte lane byte_idx (lane 0 = bits BYTE_W-1:0, little-endian); add it to checksum; increment byte_idx.
  - When the byte completes the word (byte_idx == WORD_BYTES-1), go to WRITE.
- Overflow: in_valid=1 while full in ASSEMBLE with load_mode=1 sets err and drops the byte. err stays set until the next load entry or reset.
- WRITE: assert mem_we for one cycle with mem_addr and the assembled word. Then increment mem_addr and word_count, clear byte_idx and the buffer, and return to ASSEMBLE.
- ASSEMBLE, load_mode=0: load_mode takes priority over in_valid, and in_ready is combinationally 0, so no byte is accepted. If byte_idx==0, go to DONE. Otherwise go to FLUSH.
- FLUSH: write the partial word with unfilled lanes zero; mem_we, mem_addr and word_count update exactly as in WRITE. Then go to DONE.
- load_mode falling during WRITE is ignored until WRITE completes; it is then evaluated in ASSEMBLE.
- DONE: cpu_run = !err. load_mode=1 starts a reload (→ ASSEMBLE with clears).
- mem_addr never wraps; writes are prevented by the full check.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - word_count=0, checksum=0, err=0, cpu_run=0
- in_ready is combinational from state, load_mode and full. All other outputs are registered.
- Write latency: mem_we is high the cycle after the last byte of a word is accepted.
- Throughput: WORD_BYTES bytes per WORD_BYTES+1 cycles; in_ready=0 during WRITE and FLUSH.
- End of load:
  - With no partial word, cpu_run rises 1 cycle after the first load_mode=0 cycle in ASSEMBLE.
  - With a partial word, cpu_run rises 2 cycles after that cycle (FLUSH, then DONE).
- rst asserted mid-load or mid-write: all outputs return to reset values immediately. Memory contents already written are not undone.

## Test plan
- Basic load (defaults): load_mode=1; send 0x34,0x12,0x78,0x56 back-to-back; load_mode=0.
  - Expect mem_we pulses writing addr0=0x1234 and addr1=0x5678.
  - Expect word_count=2, checksum=0x14, err=0, cpu_run=1.
- Partial flush: send 0xAA,0xBB,0xCC, then load_mode=0.
  - Expect addr0=0xBBAA, then FLUSH writing addr1=0x00CC.
  - Expect word_count=2, checksum=0x31.
- Overflow (DEPTH=2): send 6 bytes.
  - Expect 2 writes; in_ready=0 after the 4th byte; err=1 on the 5th valid.
  - After load_mode=0, expect cpu_run=0; a new load_mode=1 clears err.
- Priority: in_valid=1 with byte 0x99 in the same cycle load_mode falls in ASSEMBLE.
  - Expect in_ready=0, the byte is not counted, checksum is unchanged.
- Reset mid-operation: assert rst the cycle mem_we is high.
  - Expect all outputs at reset values in that cycle, state IDLE.
  - A subsequent load restarts at addr0.
- Parametrised (BYTE_W=8, WORD_BYTES=4, ADDR_WIDTH=4, DEPTH=16): send bytes 0x01..0x08.
  - Expect addr0=0x04030201 and addr1=0x08070605; word_count=2; checksum=0x24.
